// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the monitor ROM synchronous-read port between the 6502
// and one secondary requester; the CPU has priority and a starvation counter forces a slot.
module rom_port_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_rdy,
  input  logic                  sec_req,
  input  logic [ADDR_WIDTH-1:0] sec_addr,
  output logic                  sec_ack,
  output logic                  sec_valid,
  output logic [DATA_WIDTH-1:0] sec_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  // state    | meaning
  // OWN_NONE | no ROM read was issued last cycle
  // OWN_CPU  | rom_data this cycle belongs to the CPU
  // OWN_SEC  | rom_data this cycle belongs to the secondary requester
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_SEC  = 2'd2
  } owner_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  owner_e                owner_q;
  owner_e                owner_d;
  logic [7:0]            starve_cnt;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [DATA_WIDTH-1:0] cpu_hold;
  logic                  grant_force;
  logic                  grant_cpu;
  logic                  grant_sec;

  // Grant decision; nothing is granted while rst is high.
  always_comb begin
    grant_force = 1'b0;
    grant_cpu   = 1'b0;
    grant_sec   = 1'b0;
    if (!rst) begin
      if (cpu_req && sec_req && (starve_cnt == LIMIT)) begin
        grant_force = 1'b1;
        grant_sec   = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else if (sec_req) begin
        grant_sec = 1'b1;
      end
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (grant_cpu) begin
      owner_d = OWN_CPU;
    end else if (grant_sec) begin
      owner_d = OWN_SEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    cpu_rdy  = ~grant_force;
    sec_ack  = grant_sec;
    rom_addr = rom_addr_q;
    if (rst) begin
      rom_addr = '0;
    end else if (grant_cpu) begin
      rom_addr = cpu_addr;
    end else if (grant_sec) begin
      rom_addr = sec_addr;
    end
    cpu_data = (owner_q == OWN_CPU) ? rom_data : cpu_hold;
  end

  // Address hold, starvation count and data return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      starve_cnt <= '0;
      cpu_hold   <= '0;
      sec_valid  <= 1'b0;
      sec_data   <= '0;
    end else begin
      rom_addr_q <= rom_addr;
      if (grant_sec) begin
        starve_cnt <= '0;
      end else if (grant_cpu && sec_req && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
      if (owner_q == OWN_CPU) begin
        cpu_hold <= rom_data;
      end
      sec_valid <= (owner_q == OWN_SEC);
      if (owner_q == OWN_SEC) begin
        sec_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed and randomized checks of rom_port_arbiter against
// a cycle-level reference model of the sharing rules; a behavioural ROM holds rom[a]=a[7:0].
module tb_rom_port_arbiter;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_rdy;
  logic          sec_req;
  logic [AW-1:0] sec_addr;
  logic          sec_ack;
  logic          sec_valid;
  logic [DW-1:0] sec_data;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int            m_wait = 0;
  logic [AW-1:0] m_last_addr = '0;
  bit            m_cpu_prev = 1'b0;
  logic [AW-1:0] m_cpu_prev_addr = '0;
  logic [DW-1:0] m_cpu_hold = '0;
  bit            m_s1 = 1'b0;
  logic [AW-1:0] m_s1_addr = '0;
  bit            m_sv = 1'b0;
  logic [DW-1:0] m_sd = '0;
  bit            m_last_force = 1'b0;
  bit            m_last_ack = 1'b0;
  int            sec_wait = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_rdy  (cpu_rdy),
    .sec_req  (sec_req),
    .sec_addr (sec_addr),
    .sec_ack  (sec_ack),
    .sec_valid(sec_valid),
    .sec_data (sec_data),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    return a[7:0];
  endfunction

  always @(posedge clk) rom_data <= rom_val(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One bus cycle: drive, check every output against the model, advance the model.
  task automatic cycle(input bit r, input bit cr, input logic [AW-1:0] ca,
                       input bit sr, input logic [AW-1:0] sa);
    bit            f;
    bit            g_cpu;
    bit            g_sec;
    logic [AW-1:0] ea;
    logic [DW-1:0] ecd;
    @(negedge clk);
    rst      = r;
    cpu_req  = cr;
    cpu_addr = ca;
    sec_req  = sr;
    sec_addr = sa;
    #1;
    f     = !r && cr && sr && (m_wait == LIMIT);
    g_cpu = !r && cr && !f;
    g_sec = !r && sr && !g_cpu;
    ea    = r ? '0 : (g_cpu ? ca : (g_sec ? sa : m_last_addr));
    ecd   = m_cpu_prev ? rom_val(m_cpu_prev_addr) : m_cpu_hold;
    chk("cpu_rdy", 32'(cpu_rdy), 32'(!f));
    chk("sec_ack", 32'(sec_ack), 32'(g_sec));
    chk("rom_addr", 32'(rom_addr), 32'(ea));
    chk("cpu_data", 32'(cpu_data), 32'(ecd));
    chk("sec_valid", 32'(sec_valid), 32'(m_sv));
    chk("sec_data", 32'(sec_data), 32'(m_sd));
    if (r) begin
      sec_wait = 0;
    end else if (sr) begin
      sec_wait++;
      if (sec_ack) begin
        chk("sec_wait_bound", 32'(sec_wait <= LIMIT + 1), 32'd1);
        sec_wait = 0;
      end
    end
    if (r) begin
      m_wait      = 0;
      m_last_addr = '0;
      m_cpu_prev  = 1'b0;
      m_cpu_hold  = '0;
      m_s1        = 1'b0;
      m_sv        = 1'b0;
      m_sd        = '0;
    end else begin
      if (g_sec) m_wait = 0;
      else if (g_cpu && sr) m_wait++;
      m_last_addr = ea;
      if (m_cpu_prev) m_cpu_hold = rom_val(m_cpu_prev_addr);
      m_cpu_prev      = g_cpu;
      m_cpu_prev_addr = ca;
      m_sv = m_s1;
      if (m_s1) m_sd = rom_val(m_s1_addr);
      m_s1      = g_sec;
      m_s1_addr = sa;
    end
    m_last_force = f;
    m_last_ack   = g_sec;
    @(posedge clk);
  endtask

  initial begin
    bit            r;
    bit            cr;
    bit            sr;
    logic [AW-1:0] ca;
    logic [AW-1:0] sa;

    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    sec_req  = 1'b0;
    sec_addr = '0;
    repeat (2) @(posedge clk);

    // reset held with both requests active
    cycle(1'b1, 1'b1, 13'h0123, 1'b1, 13'h0456);
    cycle(1'b1, 1'b1, 13'h0123, 1'b1, 13'h0456);
    #1;
    chk("rst_cpu_data", 32'(cpu_data), 32'h0);
    chk("rst_sec_data", 32'(sec_data), 32'h0);

    // CPU only
    cycle(1'b0, 1'b1, 13'h1FFC, 1'b0, 13'h0);
    #1;
    chk("cpu_read_fc", 32'(cpu_data), 32'hFC);
    cycle(1'b0, 1'b1, 13'h1FFD, 1'b0, 13'h0);
    #1;
    chk("cpu_read_fd", 32'(cpu_data), 32'hFD);

    // secondary on an idle bus, address advanced each ack
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 13'h0, (i < 4), 13'(16'h0010 + i));
      #1;
      if (i >= 1 && i <= 4) begin
        chk("sec_seq_valid", 32'(sec_valid), 32'd1);
        chk("sec_seq_data", 32'(sec_data), 32'(8'h10 + i - 1));
      end
    end

    // starvation: CPU keeps reading 0x0055, secondary waits on 0x0ABC
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 13'h0055, (i <= 3), 13'h0ABC);
      #1;
      if (i == 3) chk("cpu_hold_in_force", 32'(cpu_data), 32'h55);
      if (i == 4) begin
        chk("force_sec_valid", 32'(sec_valid), 32'd1);
        chk("force_sec_data", 32'(sec_data), 32'hBC);
        chk("cpu_retry_data", 32'(cpu_data), 32'h55);
      end
    end
    // counter restarts from zero: the next forced slot again comes after LIMIT CPU grants
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 13'h0056, 1'b1, 13'h0ABD);
    cycle(1'b0, 1'b0, 13'h0, 1'b0, 13'h0);

    // reset while a secondary read is in flight
    cycle(1'b0, 1'b0, 13'h0, 1'b1, 13'h0777);
    cycle(1'b1, 1'b0, 13'h0, 1'b0, 13'h0);
    #1;
    chk("rst_drops_read", 32'(sec_valid), 32'd0);
    cycle(1'b0, 1'b0, 13'h0, 1'b1, 13'h0778);
    cycle(1'b0, 1'b0, 13'h0, 1'b0, 13'h0);
    #1;
    chk("post_rst_valid", 32'(sec_valid), 32'd1);
    chk("post_rst_data", 32'(sec_data), 32'h78);

    // randomized traffic; CPU repeats after a forced cycle, secondary holds until acked
    cr = 1'b0;
    ca = '0;
    sr = 1'b0;
    sa = '0;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 249) == 0);
      if (!m_last_force) begin
        cr = ($urandom_range(0, 99) < 65);
        ca = 13'($urandom);
      end
      if (!sr || m_last_ack) begin
        sr = ($urandom_range(0, 99) < 50);
        sa = 13'($urandom);
      end
      cycle(r, cr, ca, sr, sa);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Shares the single synchronous-read port of the 8 KB monitor ROM between the 6502 CPU and one secondary read requester, e.g. a debug dump engine or a boot checksum scanner. The CPU has priority. A starvation counter guarantees the secondary requester a slot: when the limit is reached, the arbiter deasserts the CPU RDY line for one cycle. The block sits between the address decoder/CPU bus and the ROM instance, and drives the ROM address.

## Interface
- ADDR_WIDTH, 13, ROM word-address width (8 KB).
- DATA_WIDTH, 8, ROM data width.
- STARVE_LIMIT, 15, consecutive denied secondary cycles before a forced grant. Legal range is 1..255.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU is performing a ROM read this cycle (ROM chip select AND CPU clock enable).
- cpu_addr  in  ADDR_WIDTH  CPU address, low bits.
- cpu_data  out  DATA_WIDTH  read data returned to the CPU.
- cpu_rdy  out  1  to 6502 RDY; 0 means the CPU must repeat this cycle.
- sec_req  in  1  secondary read request; held until acknowledged.
- sec_addr  in  ADDR_WIDTH  secondary address; stable while sec_req=1.
- sec_ack  out  1  request accepted this cycle (combinational).
- sec_valid  out  1  one-cycle pulse; sec_data holds a valid word.
- sec_data  out  DATA_WIDTH  registered secondary read data.
- rom_addr  out  ADDR_WIDTH  address to the ROM.
- rom_data  in  DATA_WIDTH  ROM output, valid one cycle after rom_addr.

## Operation
- Per-cycle grant decision. Each bullet is evaluated combinationally, first match wins:
  - FORCE: cpu_req=1, sec_req=1, starve_cnt==STARVE_LIMIT → grant SEC, cpu_rdy=0.
  - CPU: cpu_req=1 → grant CPU.
  - SEC: sec_req=1 → grant SEC.
  - IDLE: no grant.
- cpu_rdy=0 only in FORCE; otherwise 1.
- sec_ack = SEC or FORCE grant.
- rom_addr:
  - CPU grant → cpu_addr.
  - SEC/FORCE grant → sec_addr.
  - IDLE → holds the previously driven address (register rom_addr_q; reset value 0).
- owner_q (NONE/CPU/SEC) registers this cycle's grant and describes the data arriving next cycle.
- starve_cnt (8 bit):
  - Cleared on reset and on any SEC/FORCE grant.
  - Incremented when sec_req=1 and CPU is granted.
  - Otherwise holds.
  - Never exceeds STARVE_LIMIT.
- CPU data return:
  - cpu_data = rom_data when owner_q==CPU.
  - Otherwise cpu_data = cpu_hold, a register loaded from rom_data whenever owner_q==CPU; reset value 0.
- Secondary data return: when owner_q==SEC, sec_data<=rom_data and sec_valid<=1 at that edge; otherwise sec_valid<=0. sec_data holds between pulses.
- Back-to-back secondary requests are pipelined, one per granted cycle. No ordering hazard exists because there is a single requester.
- The CPU retries after a FORCE cycle: the 6502 re-presents the same cpu_req/cpu_addr next cycle with starve_cnt=0, so the CPU is then granted.

## Timing
- Reset values: cpu_rdy=1, sec_ack=0 (because sec_req is ignored during rst), sec_valid=0, sec_data=0, cpu_data=0, rom_addr=0, owner_q=NONE, starve_cnt=0.
- While rst=1, no grants are issued, regardless of cpu_req and sec_req.
- CPU read: addr presented in cycle N → cpu_data valid in cycle N+1 (one-cycle ROM latency, no added latency).
- Secondary read: sec_ack in cycle N → rom_data in N+1 → sec_valid=1 and sec_data valid in N+2.
- Maximum secondary wait under continuous CPU traffic is STARVE_LIMIT+1 cycles, measured from sec_req rising to sec_ack.
- Reset mid-operation: an in-flight secondary read (acked, sec_valid not yet pulsed) is dropped. No sec_valid pulse follows reset.
- Simultaneous cpu_req and sec_req below the limit: CPU is granted, starve_cnt increments, sec_ack=0.

## Test plan
- Reset: assert rst 2 cycles with cpu_req=sec_req=1 → sec_ack=0, cpu_rdy=1, sec_valid=0, rom_addr=0 throughout; all outputs equal their reset values on release.
- CPU only: ROM preloaded with rom[a]=a[7:0]; cpu_req=1, cpu_addr=0x1FFC then 0x1FFD → cpu_data=0xFC then 0xFD one cycle after each; sec_ack never asserts.
- Secondary on idle bus: sec_req held 4 cycles at 0x0010..0x0013 (addr advanced on ack) → sec_ack each cycle; sec_valid pulses 2 cycles later with data 0x10..0x13 in order.
- Starvation: STARVE_LIMIT=3, cpu_req continuous, sec_req=1 at 0x0ABC → CPU granted 3 cycles, 4th cycle cpu_rdy=0 and sec_ack=1, sec_data=0xBC two cycles later; CPU's repeated address is served next cycle with correct data; starve_cnt returns to 0.
- CPU hold: CPU reads 0x0055; FORCE cycle follows → cpu_data stays 0x55 during the non-CPU-owned cycle.
- Reset mid-read: sec_ack in cycle N, rst=1 in N+1 → sec_valid stays 0 in N+2; first post-reset secondary read completes normally.
